// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data port: one request per handshake, with programmable wait states in front of an on-chip word RAM.
// Optional byte-lane write strobes are enabled by defining DMEM_BYTE_STROBE_EN.
module dmem_responder #(
    parameter int ADDR_WIDTH = 6,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  req_be,
`endif
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int LAT_EFF = (LATENCY < 1) ? 1 : LATENCY;
    localparam int CNT_W   = $clog2(LAT_EFF + 1);
    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Misaligned or beyond the implemented word range.
    function automatic logic addr_err(input logic [31:0] a);
        logic [31:0] hi;
        hi = a >> (ADDR_WIDTH + 2);
        return (a[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return merged;
    endfunction

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    wr_r;
    logic [31:0]             addr_r;
    logic [31:0]             wdata_r;
    logic [3:0]              lane_en_s;
    logic                    err_s;
    logic                    fire_s;
    logic                    mem_we_s;
    logic [ADDR_WIDTH-1:0]   idx_s;
    logic [31:0]             mem_r [0:DEPTH-1];

`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]              be_r;

    // Lane strobes captured alongside the request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            be_r <= 4'b0000;
        end else if ((state_r == ST_IDLE) && req_valid && req_ready) begin
            be_r <= req_be;
        end
    end

    assign lane_en_s = be_r;
`else
    assign lane_en_s = 4'b1111;
`endif

    assign err_s    = addr_err(addr_r);
    assign idx_s    = addr_r[ADDR_WIDTH+1:2];
    assign fire_s   = (state_r == ST_WAIT) && (cnt_r == '0);
    assign mem_we_s = fire_s && wr_r && !err_s;

    // Word RAM; contents survive reset, and an aborted write never fires since reset forces IDLE.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[idx_s] <= merge_lanes(mem_r[idx_s], wdata_r, lane_en_s);
        end
    end

    // Request/response sequencer with registered handshake and response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            wr_r      <= 1'b0;
            addr_r    <= 32'd0;
            wdata_r   <= 32'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        wr_r      <= req_write;
                        addr_r    <= req_addr;
                        wdata_r   <= req_wdata;
                        req_ready <= 1'b0;
                        cnt_r     <= CNT_LOAD;
                        state_r   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == '0) begin
                        state_r   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        if (err_s) begin
                            rsp_rdata <= 32'd0;
                            rsp_err   <= 1'b1;
                        end else if (wr_r) begin
                            rsp_rdata <= 32'd0;
                            rsp_err   <= 1'b0;
                        end else begin
                            rsp_rdata <= mem_r[idx_s];
                            rsp_err   <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // Response fields hold until the requester takes them.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (ADDR_WIDTH=6, LATENCY=2).
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  req_be;
`endif
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks;
    int failures;

    // Results of the most recent transaction
    logic [31:0] t_rdata;
    logic        t_err;
    int          t_lat;
    logic        t_rdy_acc;
    logic        t_val_after;
    logic        t_rdy_after;

    dmem_responder #(.ADDR_WIDTH(6), .LATENCY(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .req_be    (req_be),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request and take its response; inputs change 1 time unit after rising edges.
    task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL ready_timeout: req_ready=%0b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
`ifdef DMEM_BYTE_STROBE_EN
        req_be    = be;
`else
        if (be != 4'b1111) $display("note: byte enables ignored in this build");
`endif
        @(posedge clk); #1;
        req_valid = 1'b0;
        t_rdy_acc = req_ready;
        t_lat = 0;
        while (!rsp_valid && t_lat < 20) begin
            @(posedge clk); #1;
            t_lat++;
        end
        t_rdata   = rsp_rdata;
        t_err     = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready   = 1'b0;
        t_val_after = rsp_valid;
        t_rdy_after = req_ready;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
`ifdef DMEM_BYTE_STROBE_EN
        req_be = 4'b1111;
`endif
        #23;
        checks++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b000 || rsp_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: rdy=%0b val=%0b err=%0b rdata=%h required 0 0 0 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: req_ready=%0b required 1", req_ready);
        end
    endtask

    task automatic test_write_read();
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
        checks++;
        if (t_rdy_acc !== 1'b0) begin failures++; $display("FAIL wr_ready_after_accept: %0b required 0", t_rdy_acc); end
        checks++;
        if (t_lat != 2) begin failures++; $display("FAIL wr_latency: %0d required 2", t_lat); end
        checks++;
        if (t_err !== 1'b0 || t_rdata !== 32'd0) begin
            failures++; $display("FAIL wr_response: err=%0b rdata=%h required 0 00000000", t_err, t_rdata);
        end
        checks++;
        if (t_val_after !== 1'b0 || t_rdy_after !== 1'b1) begin
            failures++; $display("FAIL wr_handshake: val=%0b rdy=%0b required 0 1", t_val_after, t_rdy_after);
        end
        txn(1'b0, 32'h10, 32'h0, 4'b1111);
        checks++;
        if (t_rdata !== 32'hDEADBEEF || t_err !== 1'b0 || t_lat != 2) begin
            failures++; $display("FAIL rd_0x10: rdata=%h err=%0b lat=%0d required deadbeef 0 2", t_rdata, t_err, t_lat);
        end
    endtask

    task automatic test_errors();
        txn(1'b0, 32'h13, 32'h0, 4'b1111);
        checks++;
        if (t_err !== 1'b1 || t_rdata !== 32'd0) begin
            failures++; $display("FAIL rd_misaligned: err=%0b rdata=%h required 1 00000000", t_err, t_rdata);
        end
        txn(1'b1, 32'h12, 32'h12345678, 4'b1111);
        checks++;
        if (t_err !== 1'b1 || t_rdata !== 32'd0) begin
            failures++; $display("FAIL wr_misaligned: err=%0b rdata=%h required 1 00000000", t_err, t_rdata);
        end
        txn(1'b0, 32'h10, 32'h0, 4'b1111);
        checks++;
        if (t_rdata !== 32'hDEADBEEF || t_err !== 1'b0) begin
            failures++; $display("FAIL rd_after_err_wr: rdata=%h err=%0b required deadbeef 0", t_rdata, t_err);
        end
    endtask

    task automatic test_boundary();
        txn(1'b1, 32'hFC, 32'hCAFEF00D, 4'b1111);
        checks++;
        if (t_err !== 1'b0) begin failures++; $display("FAIL wr_0xfc: err=%0b required 0", t_err); end
        txn(1'b0, 32'hFC, 32'h0, 4'b1111);
        checks++;
        if (t_rdata !== 32'hCAFEF00D || t_err !== 1'b0) begin
            failures++; $display("FAIL rd_0xfc: rdata=%h err=%0b required cafef00d 0", t_rdata, t_err);
        end
        txn(1'b0, 32'h100, 32'h0, 4'b1111);
        checks++;
        if (t_rdata !== 32'd0 || t_err !== 1'b1) begin
            failures++; $display("FAIL rd_0x100: rdata=%h err=%0b required 00000000 1", t_rdata, t_err);
        end
        // Out-of-range write aliasing onto word 0x10 must not land
        txn(1'b1, 32'h8000_0010, 32'h0BADF00D, 4'b1111);
        txn(1'b0, 32'h10, 32'h0, 4'b1111);
        checks++;
        if (t_rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL high_addr_alias: rdata=%h required deadbeef", t_rdata);
        end
    endtask

    task automatic test_backpressure();
        int n;
        // rsp_ready high while idle must have no effect
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
        @(posedge clk); #1;
        req_addr = 32'h20; req_write = 1'b1; req_wdata = 32'h99999999;
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d: val=%0b rdata=%h err=%0b rdy=%0b required 1 deadbeef 0 0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++; $display("FAIL release_hold: val=%0b rdy=%0b required 0 1", rsp_valid, req_ready);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++; $display("FAIL no_ghost_accept: val=%0b rdy=%0b required 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_abort();
        txn(1'b1, 32'h20, 32'h11111111, 4'b1111);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b000 || rsp_rdata !== 32'd0) begin
            failures++;
            $display("FAIL abort_outputs: rdy=%0b val=%0b err=%0b rdata=%h required 0 0 0 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        txn(1'b0, 32'h20, 32'h0, 4'b1111);
        checks++;
        if (t_rdata !== 32'h11111111 || t_err !== 1'b0) begin
            failures++; $display("FAIL abort_no_write: rdata=%h err=%0b required 11111111 0", t_rdata, t_err);
        end
    endtask

    task automatic test_back_to_back();
        txn(1'b1, 32'h04, 32'hA5A5A5A5, 4'b1111);
        txn(1'b0, 32'h04, 32'h0, 4'b1111);
        checks++;
        if (t_rdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL b2b_first: rdata=%h required a5a5a5a5", t_rdata); end
        txn(1'b1, 32'h04, 32'h5A5A0001, 4'b1111);
        txn(1'b0, 32'h04, 32'h0, 4'b1111);
        checks++;
        if (t_rdata !== 32'h5A5A0001) begin failures++; $display("FAIL b2b_overwrite: rdata=%h required 5a5a0001", t_rdata); end
        txn(1'b0, 32'h10, 32'h0, 4'b1111);
        checks++;
        if (t_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_other_word: rdata=%h required deadbeef", t_rdata); end
    endtask

`ifdef DMEM_BYTE_STROBE_EN
    task automatic test_byte_strobe();
        txn(1'b1, 32'h00, 32'h00000000, 4'b1111);
        txn(1'b1, 32'h00, 32'hAABBCCDD, 4'b0101);
        txn(1'b0, 32'h00, 32'h0, 4'b0000);
        checks++;
        if (t_rdata !== 32'h00BB00DD) begin failures++; $display("FAIL be_0101: rdata=%h required 00bb00dd", t_rdata); end
        txn(1'b1, 32'h00, 32'hFFFFFFFF, 4'b0000);
        checks++;
        if (t_err !== 1'b0) begin failures++; $display("FAIL be_zero_err: err=%0b required 0", t_err); end
        txn(1'b0, 32'h00, 32'h0, 4'b0000);
        checks++;
        if (t_rdata !== 32'h00BB00DD) begin failures++; $display("FAIL be_zero_data: rdata=%h required 00bb00dd", t_rdata); end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_errors();
        test_boundary();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
`ifdef DMEM_BYTE_STROBE_EN
        test_byte_strobe();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
